// File: rtl/seq_gen_pkg.sv
// Shared state encoding, default preamble and counter sizing helper for the
// 1011 serial frame transmitter.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int SYNC_W_DEF = 4;
  localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 4'b1011;

  // Width needed to hold the largest per-state reload value without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register: parallel load, shift-left enable,
// MSB presented as the serial bit.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift_en) begin
      q <= q << 1;
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/seq_gen_1011_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, then zero guard bits,
// with every output registered from the next-state decision (Moore).
module seq_gen_1011_tx
  import seq_gen_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
  parameter int                GAP_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              Data_out,
  output logic              tx_active,
  output logic              done
);

  localparam int CNT_W = cnt_width(SYNC_W, DATA_W, GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_SYNC = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load;
  logic             shift_en;
  logic             shift_msb;
  logic             pat_bit;
  logic             line_nxt;

  // The edge that puts a payload bit on the line also shifts it out, so the
  // register MSB is always the next payload bit to transmit.
  assign shift_en = (state_nxt == DATA);

  piso_shift #(
    .W(DATA_W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift_en(shift_en),
    .din     (data_in),
    .msb     (shift_msb)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SYNC;
          cnt_nxt   = CNT_SYNC;
          load      = 1'b1;
        end
      end
      SYNC: begin
        if (cnt == '0) begin
          state_nxt = DATA;
          cnt_nxt   = CNT_DATA;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_GAP;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Preamble bit selected by the counter value the next cycle will hold.
  assign pat_bit = |(SYNC_PAT & (SYNC_W'(1) << cnt_nxt));

  always_comb begin
    line_nxt = 1'b0;
    case (state_nxt)
      SYNC:    line_nxt = pat_bit;
      DATA:    line_nxt = shift_msb;
      default: line_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      Data_out  <= 1'b0;
      ready     <= 1'b1;
      tx_active <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      Data_out  <= line_nxt;
      ready     <= (state_nxt == IDLE);
      tx_active <= (state_nxt != IDLE);
      done      <= (state_nxt == GAP) && (cnt_nxt == '0);
    end
  end

endmodule

// File: tb/tb_seq_gen_1011_tx.sv
// Bench for seq_gen_1011_tx: a bit-queue frame model plus a behavioural 1011
// detector on the line, driven by directed and randomized stimulus.
module tb_seq_gen_1011_tx;

  localparam int DATA_W  = 8;
  localparam int SYNC_W  = 4;
  localparam int GAP_CYC = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              Data_out;
  logic              tx_active;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  // Bits still to appear on the line for the frame in flight (front = now).
  bit         mq[$];
  logic [3:0] pat_v = 4'b1011;

  logic       line_prev;
  logic [3:0] det_hist = 4'b0;
  int         det_n = 0;
  logic       det_out = 1'b0;

  seq_gen_1011_tx #(
    .DATA_W  (DATA_W),
    .SYNC_W  (SYNC_W),
    .SYNC_PAT(4'b1011),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .ready    (ready),
    .Data_out (Data_out),
    .tx_active(tx_active),
    .done     (done)
  );

  always #5 clk = ~clk;

  // {ready, tx_active, done, Data_out} expected in the current cycle.
  function automatic logic [3:0] exp_vec();
    logic b;
    b = (mq.size() != 0) ? mq[0] : 1'b0;
    return {mq.size() == 0, mq.size() != 0, mq.size() == 1, b};
  endfunction

  task automatic cycle();
    line_prev = Data_out;
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else if (mq.size() == 0) begin
      if (start) begin
        for (int i = SYNC_W - 1; i >= 0; i--) mq.push_back(pat_v[i]);
        for (int i = DATA_W - 1; i >= 0; i--) mq.push_back(data_in[i]);
        for (int i = 0; i < GAP_CYC; i++) mq.push_back(1'b0);
      end
    end else begin
      void'(mq.pop_front());
    end
    det_hist = {det_hist[2:0], line_prev};
    det_n++;
    det_out = 1'b0;
    if (det_n >= 4 && det_hist == 4'b1011) begin
      det_out = 1'b1;
      det_n   = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_in = '0;
    cycle();
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({ready, tx_active, done, Data_out} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %b want 1000", c, {ready, tx_active, done, Data_out});
      end
      cycle();
    end
  endtask

  task automatic test_frame();
    logic [12:0] cap;
    int done_c;
    cap = '0; done_c = -1;
    data_in = 8'hA5; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      cap = {cap[11:0], Data_out};
      if (done) done_c = c;
      n_checks++;
      if ({ready, tx_active, done, Data_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL frame cyc %0d: got %b want %b", c, {ready, tx_active, done, Data_out}, exp_vec());
      end
      cycle();
    end
    n_checks++;
    if (cap !== 13'b1011_10100101_0) begin
      n_fail++;
      $display("FAIL frame_bits: got %b want 1011101001010", cap);
    end
    n_checks++;
    if (done_c != 13) begin
      n_fail++;
      $display("FAIL frame_done_cycle: got %0d want 13", done_c);
    end
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_ready_after: got %b want 1", ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] cap;
    cap = '0;
    data_in = 8'hFF; start = 1'b1;
    cycle();
    data_in = 8'h00;
    for (int c = 1; c <= 27; c++) begin
      cap = {cap[25:0], Data_out};
      n_checks++;
      if ({ready, tx_active, done, Data_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b cyc %0d: got %b want %b", c, {ready, tx_active, done, Data_out}, exp_vec());
      end
      cycle();
    end
    start = 1'b0;
    n_checks++;
    if (cap !== 27'b1011_11111111_0_0_1011_00000000_0) begin
      n_fail++;
      $display("FAIL b2b_bits: got %b want 101111111111001011000000000", cap);
    end
  endtask

  task automatic test_busy();
    logic [12:0] cap;
    cap = '0;
    data_in = 8'h3C; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      start = (c == 3 || c == 9);
      if (c < 13) data_in = DATA_W'($urandom);
      if (c <= 13) cap = {cap[11:0], Data_out};
      n_checks++;
      if ({ready, tx_active, done, Data_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL busy cyc %0d: got %b want %b", c, {ready, tx_active, done, Data_out}, exp_vec());
      end
      cycle();
    end
    start = 1'b0;
    n_checks++;
    if (cap !== 13'b1011_00111100_0) begin
      n_fail++;
      $display("FAIL busy_bits: got %b want 1011001111000", cap);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    data_in = 8'hC3; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (done) done_seen++;
      if (c == 6) rst = 1'b1;
      cycle();
    end
    rst = 1'b0;
    n_checks++;
    if ({ready, tx_active, done, Data_out} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_mid: got %b want 1000", {ready, tx_active, done, Data_out});
    end
    for (int c = 0; c < 12; c++) begin
      if (done) done_seen++;
      cycle();
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL rst_mid_done: got %0d pulses want 0", done_seen);
    end
    rst = 1'b1; start = 1'b1;
    cycle();
    rst = 1'b0; start = 1'b0;
    cycle();
    n_checks++;
    if ({ready, tx_active, done, Data_out} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_start: got %b want 1000", {ready, tx_active, done, Data_out});
    end
  endtask

  task automatic test_loopback();
    int pulses;
    int pulse_c;
    pulses = 0; pulse_c = -1;
    det_hist = 4'b0; det_n = 0;
    data_in = 8'hA5; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (det_out) begin
        pulses++;
        pulse_c = c;
      end
      cycle();
    end
    n_checks++;
    if (pulses != 1 || pulse_c != 5) begin
      n_fail++;
      $display("FAIL loopback: got %0d pulses at cycle %0d want 1 at 5", pulses, pulse_c);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 59) == 0);
      start   = ($urandom_range(0, 2) == 0);
      data_in = DATA_W'($urandom);
      cycle();
      n_checks++;
      if ({ready, tx_active, done, Data_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", c, {ready, tx_active, done, Data_out}, exp_vec());
      end
    end
    rst = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_loopback();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
